div_sequencer: RTL and testbench

- Multi-cycle sequencer for the M-extension divide/remainder operations (DIV, DIVU, REM, REMU) of the RV32 core.
- Sits beside the combinational ALU. It replaces the single-cycle divide path with a radix-2 restoring iteration and stalls the pipeline through busy.
- The control unit issues one operation with start. Results return with a one-cycle done pulse.
- Handles the RISC-V divide-by-zero and signed-overflow cases without iterating.

---
 rtl/div_sequencer.sv | 124 ++++++++++++
 tb/tb_div_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for RV32 DIV/DIVU/REM/REMU.
// Special cases (divide by zero, signed overflow) finish in one cycle without iterating.
module div_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      funct,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned     CW      = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;
  state_t state, state_next;

  logic [XLEN-1:0] quo, rem, divisor;
  logic [CW-1:0]   cnt;
  logic            op_rem, neg_q, neg_r;

  logic            is_signed, div_zero, overflow;
  logic [XLEN-1:0] a_mag, b_mag, special_val, q_fix, r_fix, result_next;
  logic [XLEN:0]   trial;
  logic            load, step, done_next;

  always_comb begin
    is_signed   = ~funct[0];
    div_zero    = (operand_b == '0);
    overflow    = is_signed && (operand_a == MIN_NEG) && (operand_b == '1);
    a_mag       = (is_signed && operand_a[XLEN-1]) ? -operand_a : operand_a;
    b_mag       = (is_signed && operand_b[XLEN-1]) ? -operand_b : operand_b;
    special_val = div_zero ? (funct[1] ? operand_a : '1)
                           : (funct[1] ? '0 : MIN_NEG);
    // Shifted remainder needs one extra bit: it can reach 2*divisor-1.
    trial       = {rem, quo[XLEN-1]} - {1'b0, divisor};
    q_fix       = neg_q ? -quo : quo;
    r_fix       = neg_r ? -rem : rem;
  end

  always_comb begin
    state_next  = state;
    done_next   = 1'b0;
    result_next = result;
    load        = 1'b0;
    step        = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (div_zero || overflow) begin
              result_next = special_val;
              done_next   = 1'b1;
            end else begin
              load       = 1'b1;
              state_next = DIVIDE;
            end
          end
        end
        DIVIDE: begin
          step = 1'b1;
          if (cnt == CW'(XLEN - 1)) state_next = FINISH;
        end
        FINISH: begin
          result_next = op_rem ? r_fix : q_fix;
          done_next   = 1'b1;
          state_next  = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done    <= 1'b0;
      result  <= '0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      cnt     <= '0;
      op_rem  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      done   <= done_next;
      result <= result_next;
      if (load) begin
        quo     <= a_mag;
        divisor <= b_mag;
        rem     <= '0;
        cnt     <= '0;
        op_rem  <= funct[1];
        neg_q   <= is_signed & (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
        neg_r   <= is_signed & operand_a[XLEN-1];
      end else if (step) begin
        cnt <= cnt + CW'(1);
        if (!trial[XLEN]) begin
          rem <= trial[XLEN-1:0];
          quo <= {quo[XLEN-2:0], 1'b1};
        end else begin
          rem <= {rem[XLEN-2:0], quo[XLEN-1]};
          quo <= {quo[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed and random ops against an arithmetic model.
module tb_div_sequencer;
  localparam int unsigned XLEN = 32;

  logic        clock = 1'b0;
  logic        reset, start, flush;
  logic [1:0]  funct;
  logic [31:0] operand_a, operand_b;
  logic        busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  div_sequencer #(.XLEN(XLEN)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .funct     (funct),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clock = ~clock;

  function automatic bit is_special(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
    case (f)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  task automatic run_op(input string name, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int lat, exp_lat;
    bit saw_busy, both;
    exp     = model(f, a, b);
    exp_lat = is_special(f, a, b) ? 1 : XLEN + 2;
    @(negedge clock);
    funct = f; operand_a = a; operand_b = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 1; saw_busy = busy; both = busy && done;
    while (!done && lat < 200) begin
      @(negedge clock);
      lat++;
      saw_busy |= busy;
      both |= busy && done;
    end
    n_cmp++;
    if (done !== 1'b1 || lat != exp_lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d cycles (done=%b), want %0d", name, lat, done, exp_lat);
    end
    n_cmp++;
    if (result !== exp) begin
      n_bad++;
      $display("FAIL %s result f=%0d a=%h b=%h: got %h, want %h", name, f, a, b, result, exp);
    end
    n_cmp++;
    if (both || (saw_busy != (exp_lat != 1))) begin
      n_bad++;
      $display("FAIL %s busy: saw_busy=%b overlap_with_done=%b, want saw_busy=%b overlap=0",
               name, saw_busy, both, exp_lat != 1);
    end
    @(negedge clock);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_pulse: done=%b one cycle later, want 0", name, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct = 2'b00;
    operand_a = '0; operand_b = '0;
    #12;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, want 0 0 0", busy, done, result);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7);
    run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE);
    run_op("div_5_0",    2'b00, 32'd5, 32'd0);
    run_op("remu_5_0",   2'b11, 32'd5, 32'd0);
    run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [1:0]  f;
    for (int i = 0; i < 30; i++) begin
      f = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3:    b = 32'($urandom_range(1, 20)) ^ (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd0);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op("random", f, a, b);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clock);
    funct = 2'b01; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      if (lat == 10) begin
        funct = 2'b00; operand_a = 32'd77; operand_b = 32'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || lat != XLEN + 2) begin
      n_bad++;
      $display("FAIL ignore_start latency: got %0d (done=%b), want %0d", lat, done, XLEN + 2);
    end
    n_cmp++;
    if (result !== 32'd333) begin
      n_bad++;
      $display("FAIL ignore_start result: got %h, want %h", result, 32'd333);
    end
  endtask

  task automatic test_flush();
    bit seen;
    @(negedge clock);
    funct = 2'b01; operand_a = 32'hDEAD_BEEF; operand_b = 32'd17; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (19) @(negedge clock);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_pre_busy: busy=%b, want 1", busy);
    end
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_abort: busy=%b done=%b, want 0 0", busy, done);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      seen |= done | busy;
    end
    n_cmp++;
    if (seen || result !== 32'd333) begin
      n_bad++;
      $display("FAIL flush_quiet: activity=%b result=%h, want 0 and %h", seen, result, 32'd333);
    end
    funct = 2'b01; operand_a = 32'd9; operand_b = 32'd0; start = 1'b1; flush = 1'b1;
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    seen = done | busy;
    repeat (3) begin
      @(negedge clock);
      seen |= done | busy;
    end
    n_cmp++;
    if (seen || result !== 32'd333) begin
      n_bad++;
      $display("FAIL flush_wins_start: activity=%b result=%h, want 0 and %h", seen, result, 32'd333);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    funct = 2'b01; operand_a = 32'd12345; operand_b = 32'd11; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h, want 0 0 0", busy, done, result);
    end
    @(negedge clock);
    reset = 1'b0;
    run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1);
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clock);
    funct = 2'b01; operand_a = 32'd50; operand_b = 32'd6; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    n_cmp++;
    if (done !== 1'b1 || result !== 32'd8) begin
      n_bad++;
      $display("FAIL b2b_first: done=%b result=%h, want 1 %h", done, result, 32'd8);
    end
    funct = 2'b10; operand_a = 32'hFFFF_FF9C; operand_b = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept: busy=%b after start in done cycle, want 1", busy);
    end
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    n_cmp++;
    if (done !== 1'b1 || lat != XLEN + 2 || result !== 32'hFFFF_FFFE) begin
      n_bad++;
      $display("FAIL b2b_second: done=%b lat=%0d result=%h, want 1 %0d %h",
               done, lat, result, XLEN + 2, 32'hFFFF_FFFE);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
